// File: rtl/bus_ctrl.sv
// bus_ctrl -- single-master to four-slave bus controller.
//
// A core request is checked in IDLE. Legal requests are latched and driven to
// the decoded slave during ACCESS until that slave acknowledges or the wait
// budget of TIMEOUT cycles runs out. Illegal requests skip ACCESS. Every
// transaction finishes with a one-cycle DONE that pulses o_BUS_GNT.
//
// Ports
//   i_CLK, i_RST         clock, synchronous active-high reset
//   i_BUS_REQ            core request, held stable until o_BUS_GNT
//   i_BUS_ADDR/WDATA     byte address / write data
//   i_BUS_WE/RE          write / read strobe (exactly one per legal request)
//   i_BUS_HB             access size: 00 byte, 01 half, 10 word, 11 illegal
//   o_BUS_GNT            one-cycle completion pulse
//   o_BUS_RDATA/ERR      read data / error flag, valid while o_BUS_GNT=1
//   o_S_SEL              one-hot slave select (ACCESS only)
//   o_S_ADDR/WDATA       latched address / write data
//   o_S_WE/RE            latched strobes, active only while a slave is selected
//   o_S_BE               byte enables for the latched access
//   i_S_RDATA            slave k read data on bits [32k+31:32k]
//   i_S_ACK              per-slave completion
module bus_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic         i_CLK,
    input  logic         i_RST,
    input  logic         i_BUS_REQ,
    input  logic [31:0]  i_BUS_ADDR,
    input  logic [31:0]  i_BUS_WDATA,
    input  logic         i_BUS_WE,
    input  logic         i_BUS_RE,
    input  logic [1:0]   i_BUS_HB,
    output logic         o_BUS_GNT,
    output logic [31:0]  o_BUS_RDATA,
    output logic         o_BUS_ERR,
    output logic [3:0]   o_S_SEL,
    output logic [31:0]  o_S_ADDR,
    output logic [31:0]  o_S_WDATA,
    output logic         o_S_WE,
    output logic         o_S_RE,
    output logic [3:0]   o_S_BE,
    input  logic [127:0] i_S_RDATA,
    input  logic [3:0]   i_S_ACK
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      addr_q, addr_nxt;
    logic [31:0]      wdata_q, wdata_nxt;
    logic             we_q, we_nxt;
    logic             re_q, re_nxt;
    logic [1:0]       hb_q, hb_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [31:0]      rdata_q, rdata_nxt;
    logic             err_q, err_nxt;

    // Request legality, evaluated on the live bus inputs in IDLE.
    logic misaligned, unmapped, req_bad;
    assign misaligned = ((i_BUS_HB == HB_HALF) && i_BUS_ADDR[0]) ||
                        ((i_BUS_HB == HB_WORD) && (i_BUS_ADDR[1:0] != 2'b00));
    assign unmapped   = (i_BUS_ADDR[31:30] != 2'b00);
    assign req_bad    = (i_BUS_WE && i_BUS_RE) || (i_BUS_HB == 2'b11) ||
                        misaligned || unmapped;

    // In ACCESS the latched address is always mapped, so bits [29:28]
    // alone identify the slave.
    logic [1:0]  slave_idx;
    logic        sel_ack;
    logic [31:0] slave_rdata;
    assign slave_idx   = addr_q[29:28];
    assign sel_ack     = i_S_ACK[slave_idx];
    assign slave_rdata = i_S_RDATA[{slave_idx, 5'b00000} +: 32];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            hb_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            we_q    <= we_nxt;
            re_q    <= re_nxt;
            hb_q    <= hb_nxt;
            cnt_q   <= cnt_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        we_nxt    = we_q;
        re_nxt    = re_q;
        hb_nxt    = hb_q;
        cnt_nxt   = cnt_q;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // A request with neither strobe set is not a request.
                if (i_BUS_REQ && (i_BUS_WE || i_BUS_RE)) begin
                    rdata_nxt = '0;
                    if (req_bad) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ACCESS;
                        err_nxt   = 1'b0;
                        addr_nxt  = i_BUS_ADDR;
                        wdata_nxt = i_BUS_WDATA;
                        we_nxt    = i_BUS_WE;
                        re_nxt    = i_BUS_RE;
                        hb_nxt    = i_BUS_HB;
                    end
                end
            end
            ACCESS: begin
                // An ACK on the last budget cycle still counts as success.
                if (sel_ack) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b0;
                    rdata_nxt = re_q ? slave_rdata : 32'h0;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and latched fields only.
    always_comb begin
        o_BUS_GNT   = (state == DONE);
        o_BUS_RDATA = (state == DONE) ? rdata_q : 32'h0;
        o_BUS_ERR   = (state == DONE) && err_q;
        o_S_ADDR    = addr_q;
        o_S_WDATA   = wdata_q;
        o_S_SEL     = 4'b0000;
        o_S_WE      = 1'b0;
        o_S_RE      = 1'b0;
        o_S_BE      = 4'b0000;
        if (state == ACCESS) begin
            o_S_SEL = 4'b0001 << slave_idx;
            o_S_WE  = we_q;
            o_S_RE  = re_q;
            case (hb_q)
                HB_BYTE: o_S_BE = 4'b0001 << addr_q[1:0];
                HB_HALF: o_S_BE = 4'b0011 << addr_q[1:0];
                default: o_S_BE = 4'b1111;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl -- directed testbench for bus_ctrl.
//
// The stimulus process drives requests and slave responses and, for each
// transaction, queues the completion it should produce (read data, error flag
// and the cycle on which o_BUS_GNT must appear). A monitor on the falling edge
// pops that queue whenever o_BUS_GNT is high; a grant with nothing queued is an
// error. Slave-side outputs are checked directly by the stimulus process.
module tb_bus_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         bus_req;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic         bus_we;
    logic         bus_re;
    logic [1:0]   bus_hb;
    logic         bus_gnt;
    logic [31:0]  bus_rdata;
    logic         bus_err;
    logic [3:0]   s_sel;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic         s_we;
    logic         s_re;
    logic [3:0]   s_be;
    logic [127:0] s_rdata;
    logic [3:0]   s_ack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    bus_ctrl #(.TIMEOUT(16)) dut (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_BUS_REQ  (bus_req),
        .i_BUS_ADDR (bus_addr),
        .i_BUS_WDATA(bus_wdata),
        .i_BUS_WE   (bus_we),
        .i_BUS_RE   (bus_re),
        .i_BUS_HB   (bus_hb),
        .o_BUS_GNT  (bus_gnt),
        .o_BUS_RDATA(bus_rdata),
        .o_BUS_ERR  (bus_err),
        .o_S_SEL    (s_sel),
        .o_S_ADDR   (s_addr),
        .o_S_WDATA  (s_wdata),
        .o_S_WE     (s_we),
        .o_S_RE     (s_re),
        .o_S_BE     (s_be),
        .i_S_RDATA  (s_rdata),
        .i_S_ACK    (s_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion monitor.
    always @(negedge clk) begin
        exp_t e;
        if (bus_gnt === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gnt: got gnt=1 at cycle %0d, required no grant", cyc);
            end else begin
                e = sb.pop_front();
                check("gnt_cycle", 32'(cyc), 32'(e.cyc));
                check("gnt_rdata", bus_rdata, e.rdata);
                check("gnt_err", {31'b0, bus_err}, {31'b0, e.err});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic we, input logic re,
                             input logic [1:0] hb, input logic [31:0] wd);
        bus_req   = 1'b1;
        bus_addr  = a;
        bus_we    = we;
        bus_re    = re;
        bus_hb    = hb;
        bus_wdata = wd;
    endtask

    task automatic idle_bus();
        bus_req = 1'b0;
        bus_we  = 1'b0;
        bus_re  = 1'b0;
    endtask

    // Queue a completion expected lat cycles after the current one.
    task automatic expect_gnt(input logic [31:0] rd, input logic e, input int lat);
        sb.push_back('{rdata: rd, err: e, cyc: cyc + lat});
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        re;
        logic [1:0]  hb;
        string       name;
    } err_vec_t;

    err_vec_t err_vecs[5] = '{
        '{32'h5000_0000, 1'b0, 1'b1, 2'b10, "unmapped"},
        '{32'h0000_0002, 1'b0, 1'b1, 2'b10, "word_misaligned"},
        '{32'h0000_0001, 1'b1, 1'b0, 2'b01, "half_misaligned"},
        '{32'h1000_0000, 1'b1, 1'b1, 2'b10, "we_and_re"},
        '{32'h0000_0000, 1'b0, 1'b1, 2'b11, "illegal_hb"}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus_req   = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_hb    = '0;
        s_rdata   = '0;
        s_ack     = '0;

        // Reset state.
        tick(2);
        check("rst_gnt", {31'b0, bus_gnt}, 32'h0);
        check("rst_err", {31'b0, bus_err}, 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_sel", {28'b0, s_sel}, 32'h0);
        check("rst_s_we", {31'b0, s_we}, 32'h0);
        check("rst_s_re", {31'b0, s_re}, 32'h0);
        check("rst_be", {28'b0, s_be}, 32'h0);
        check("rst_s_addr", s_addr, 32'h0);
        check("rst_s_wdata", s_wdata, 32'h0);
        rst = 1'b0;
        tick(1);

        // Word read, slave 1 acknowledges in the first ACCESS cycle.
        drive_req(32'h1000_0004, 1'b0, 1'b1, 2'b10, 32'h0);
        s_rdata[63:32] = 32'hCAFE_F00D;
        s_ack = 4'b0010;
        expect_gnt(32'hCAFE_F00D, 1'b0, 2);
        tick(1);
        check("rd_sel", {28'b0, s_sel}, 32'h2);
        check("rd_s_re", {31'b0, s_re}, 32'h1);
        check("rd_s_we", {31'b0, s_we}, 32'h0);
        check("rd_be", {28'b0, s_be}, 32'hF);
        check("rd_s_addr", s_addr, 32'h1000_0004);
        tick(1);
        check("rd_done_sel", {28'b0, s_sel}, 32'h0);
        idle_bus();
        s_ack = 4'b0000;
        tick(1);

        // Byte write to slave 2, ACK on the third ACCESS cycle. Bus inputs
        // change mid-transaction and must not disturb the latched access.
        drive_req(32'h2000_0003, 1'b1, 1'b0, 2'b00, 32'h0000_00AB);
        s_rdata[95:64] = 32'h1234_5678;
        expect_gnt(32'h0, 1'b0, 4);
        tick(1);
        check("wr_sel", {28'b0, s_sel}, 32'h4);
        check("wr_be", {28'b0, s_be}, 32'h8);
        check("wr_s_we", {31'b0, s_we}, 32'h1);
        check("wr_s_wdata", s_wdata, 32'h0000_00AB);
        bus_addr  = 32'h3000_0000;
        bus_wdata = 32'hFFFF_FFFF;
        bus_hb    = 2'b10;
        tick(1);
        check("wr_hold_addr", s_addr, 32'h2000_0003);
        check("wr_hold_be", {28'b0, s_be}, 32'h8);
        check("wr_hold_wdata", s_wdata, 32'h0000_00AB);
        tick(1);
        s_ack = 4'b0100;
        tick(1);
        s_ack = 4'b0000;
        idle_bus();
        tick(1);

        // Half write on the upper halfword of slave 0.
        drive_req(32'h0000_0002, 1'b1, 1'b0, 2'b01, 32'h0000_BEEF);
        s_ack = 4'b0001;
        expect_gnt(32'h0, 1'b0, 2);
        tick(1);
        check("half_be", {28'b0, s_be}, 32'hC);
        check("half_sel", {28'b0, s_sel}, 32'h1);
        tick(1);
        idle_bus();
        s_ack = 4'b0000;
        tick(1);

        // Error completions: grant on the next cycle, no slave selected.
        foreach (err_vecs[i]) begin
            drive_req(err_vecs[i].addr, err_vecs[i].we, err_vecs[i].re, err_vecs[i].hb, 32'h0);
            expect_gnt(32'h0, 1'b1, 1);
            tick(1);
            check({"err_sel_", err_vecs[i].name}, {28'b0, s_sel}, 32'h0);
            idle_bus();
            tick(1);
        end

        // A request with no strobes is ignored.
        drive_req(32'h1000_0000, 1'b0, 1'b0, 2'b10, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("nostrobe_sel", {28'b0, s_sel}, 32'h0);
        end
        idle_bus();
        tick(1);

        // Timeout on slave 0 with a stray slave 3 ACK mid-wait.
        drive_req(32'h0000_0000, 1'b0, 1'b1, 2'b10, 32'h0);
        s_rdata[31:0]   = 32'hDEAD_BEEF;
        s_rdata[127:96] = 32'hFFFF_0000;
        expect_gnt(32'h0, 1'b1, 17);
        tick(1);
        check("to_sel", {28'b0, s_sel}, 32'h1);
        tick(7);
        s_ack = 4'b1000;
        tick(1);
        s_ack = 4'b0000;
        tick(8);
        idle_bus();
        tick(1);

        // Back-to-back reads with immediate ACK: grants three cycles apart.
        drive_req(32'h1000_0000, 1'b0, 1'b1, 2'b10, 32'h0);
        s_rdata[63:32] = 32'h1111_2222;
        s_ack = 4'b0010;
        expect_gnt(32'h1111_2222, 1'b0, 2);
        tick(2);
        drive_req(32'h0000_0008, 1'b0, 1'b1, 2'b10, 32'h0);
        s_rdata[31:0] = 32'h3333_4444;
        s_ack = 4'b0011;
        expect_gnt(32'h3333_4444, 1'b0, 3);
        tick(3);
        idle_bus();
        s_ack = 4'b0000;
        tick(1);

        // Reset during ACCESS aborts; the next request is served normally.
        drive_req(32'h2000_0000, 1'b0, 1'b1, 2'b10, 32'h0);
        tick(1);
        check("abort_sel_before", {28'b0, s_sel}, 32'h4);
        rst = 1'b1;
        idle_bus();
        tick(1);
        check("abort_sel_after", {28'b0, s_sel}, 32'h0);
        check("abort_gnt", {31'b0, bus_gnt}, 32'h0);
        rst = 1'b0;
        tick(1);
        drive_req(32'h3000_000C, 1'b0, 1'b1, 2'b10, 32'h0);
        s_rdata[127:96] = 32'h5555_6666;
        s_ack = 4'b1000;
        expect_gnt(32'h5555_6666, 1'b0, 2);
        tick(2);
        idle_bus();
        s_ack = 4'b0000;
        tick(3);

        check("all_grants_seen", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_ctrl.md
BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, sets the maximum number of ACCESS-state cycles allowed for a slave ACK before an error completion.
REQ-002 i_CLK  in  1  single clock; all state changes on the rising edge.
REQ-003 i_RST  in  1  synchronous, active-high reset.
REQ-004 i_BUS_REQ  in  1  core request; held with address and controls stable until i_BUS_GNT.
REQ-005 i_BUS_ADDR  in  32  byte address.
REQ-006 i_BUS_WDATA  in  32  write data.
REQ-007 i_BUS_WE / i_BUS_RE  in  1 each  write and read strobes.
REQ-008 i_BUS_HB  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 o_BUS_GNT  out  1  one-cycle completion pulse.
REQ-010 o_BUS_RDATA  out  32  read data, valid only while o_BUS_GNT is high.
REQ-011 o_BUS_ERR  out  1  error flag, valid only while o_BUS_GNT is high.
REQ-012 o_S_SEL  out  4  one-hot slave select.
REQ-013 o_S_ADDR / o_S_WDATA  out  32 each  latched address and write data.
REQ-014 o_S_WE / o_S_RE  out  1 each  latched strobes, qualified by o_S_SEL.
REQ-015 o_S_BE  out  4  byte enables.
REQ-016 i_S_RDATA  in  128  slave k read data on bits [32k+31:32k].
REQ-017 i_S_ACK  in  4  per-slave completion.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE; all outputs are registered or decoded from state and latched fields.
REQ-019 IDLE accepts a request when i_BUS_REQ=1 and exactly one of WE/RE is 1; it latches ADDR, WDATA, WE, RE and HB, clears the timeout counter, and goes to ACCESS.
REQ-020 IDLE takes this path to DONE with error instead: REQ with WE=RE=1, illegal HB, misalignment, or an unmapped region.
REQ-021 IDLE ignores REQ while WE=RE=0.
REQ-022 Decode: ADDR[31:28]=0..3 selects slave 0..3; any other value is unmapped.
REQ-023 Misalignment: half access with ADDR[0]=1, or word access with ADDR[1:0]!=00.
REQ-024 o_S_BE values:
- byte: 1 shifted left by ADDR[1:0].
- half: 0011 shifted left by ADDR[1:0].
- word: 1111.
REQ-025 ACCESS behaviour:
- o_S_SEL is one-hot for the decoded slave.
- An ACK from the selected slave, including one in the first ACCESS cycle, captures that slave's RDATA and moves the FSM to DONE with ERR=0.
- ACKs from non-selected slaves are ignored.
REQ-026 ACCESS counter: increments each cycle without ACK; when it reaches TIMEOUT-1 without ACK, the FSM goes to DONE with ERR=1 and RDATA=0.
REQ-027 DONE behaviour:
- o_BUS_GNT=1 for exactly one cycle; o_S_SEL=0.
- RDATA is the captured value for reads and 0 for writes and errors.
- Next state is IDLE.
REQ-028 Latency: REQ seen in IDLE at cycle n with ACK in the first ACCESS cycle gives GNT at n+2; an error detected in IDLE gives GNT at n+1.
REQ-029 Back-to-back: a request present in the IDLE cycle following DONE is a new transaction; the master deasserts or changes its request after GNT.
REQ-030 Changes to i_BUS_* inputs outside IDLE have no effect; latched values govern the transaction.

Reset
REQ-031 In the cycle after i_RST=1: state=IDLE, GNT=0, ERR=0, RDATA=0, SEL=0, WE=RE=0, BE=0, counter=0; all latched fields are 0.
REQ-032 Reset during ACCESS or DONE aborts the transaction: no GNT is issued, and SEL drops in the next cycle.

Verification
REQ-033 Word read: ADDR=0x1000_0004, RE=1, HB=10; slave1 ACKs in the first ACCESS cycle with 0xCAFE_F00D -> GNT two cycles after REQ, RDATA=0xCAFE_F00D, ERR=0, SEL=0010.
REQ-034 Byte write: ADDR=0x2000_0003, HB=00, WDATA=0x0000_00AB -> SEL=0100, BE=1000, S_WE=1; slave2 ACKs after 3 cycles -> single GNT, ERR=0.
REQ-035 Errors: ADDR=0x5000_0000 read -> GNT next cycle, ERR=1, SEL never asserted; ADDR=0x0000_0002 word -> same; WE=RE=1 -> same.
REQ-036 Timeout: TIMEOUT=16, slave0 selected and never ACKs -> GNT 16 cycles after entering ACCESS, ERR=1, RDATA=0; a slave3 ACK pulsed mid-wait is ignored.
REQ-037 Back-to-back and reset: two consecutive reads with immediate ACK -> GNT pulses 3 cycles apart; i_RST asserted in ACCESS -> no GNT, SEL=0 next cycle, and the next REQ is served normally.
